fft_peak_scan_ctrl: RTL and testbench

- Sequences one peak search per FFT frame.
- On each frame-ready pulse it clears the downstream pair-wise magnitude peak detector and sweeps the FFT output RAM through the positive-frequency half, two bins per address.
- It keeps the detector's index and enable pipeline aligned with RAM read latency, then captures the detector's peak bin index and hands it to the note-mapping logic with a valid/ready handshake.

---
 rtl/fft_peak_scan_ctrl_pkg.sv | 16 +
 rtl/fft_peak_scan_ctrl_align.sv | 37 +++
 rtl/fft_peak_scan_ctrl.sv | 113 +++++++++++
 tb/tb_fft_peak_scan_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_peak_scan_ctrl_pkg.sv
// Shared types and widths for the FFT peak-scan path (controller, detector, note mapper).
package fft_scan_pkg;

    localparam int SCAN_LEN_DEFAULT = 256;
    localparam int PAIR_ADDR_W      = 9;
    localparam int BIN_IDX_W        = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SCAN,
        ST_DRAIN,
        ST_CAPTURE
    } scan_state_t;

endpackage

// File: rtl/fft_peak_scan_ctrl_align.sv
// Delays the read strobe and pair address by the RAM read latency so the
// detector's enable and index line up with the data arriving from RAM.
module scan_align_pipe #(
    parameter int RD_LAT = 2,
    parameter int IDX_W  = 9
) (
    input  logic             clk,
    input  logic             reset_fft,
    input  logic             in_en,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_en,
    output logic [IDX_W-1:0] out_idx
);

    logic [RD_LAT-1:0] en_reg;
    logic [IDX_W-1:0]  idx_reg [RD_LAT];

    always_ff @(posedge clk or posedge reset_fft) begin
        if (reset_fft) begin
            en_reg <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                idx_reg[i] <= '0;
            end
        end else begin
            en_reg[0]  <= in_en;
            idx_reg[0] <= in_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                en_reg[i]  <= en_reg[i-1];
                idx_reg[i] <= idx_reg[i-1];
            end
        end
    end

    assign out_en  = en_reg[RD_LAT-1];
    assign out_idx = idx_reg[RD_LAT-1];

endmodule

// File: rtl/fft_peak_scan_ctrl.sv
// Per-frame peak search sequencer: clears the detector, sweeps the FFT RAM in
// bin pairs, waits out the read latency and hands the peak bin to the note mapper.
module fft_peak_scan_ctrl
    import fft_scan_pkg::*;
#(
    parameter int SCAN_LEN = SCAN_LEN_DEFAULT,
    parameter int ADDR_W   = PAIR_ADDR_W,
    parameter int RD_LAT   = 2,
    parameter int SKIP_DC  = 1
) (
    input  logic              clk,
    input  logic              reset_fft,
    input  logic              fft_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              det_clear,
    output logic              det_en,
    output logic [ADDR_W-1:0] det_index,
    input  logic [ADDR_W:0]   peak_idx_in,
    output logic [ADDR_W:0]   result_idx,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(SCAN_LEN - 1);
    localparam logic [2:0]        DRAIN_LAST = 3'(RD_LAT);

    scan_state_t state_reg;
    logic [2:0]  drain_cnt_reg;
    logic        pipe_en;

    // DC masking is applied before the delay line, so det_en stays a plain register output.
    assign pipe_en = rd_en && !((SKIP_DC != 0) && (rd_addr == '0));

    always_ff @(posedge clk or posedge reset_fft) begin
        if (reset_fft) begin
            state_reg     <= ST_IDLE;
            drain_cnt_reg <= '0;
            rd_en         <= 1'b0;
            rd_addr       <= '0;
            det_clear     <= 1'b0;
            result_idx    <= '0;
            result_valid  <= 1'b0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            det_clear <= 1'b0;
            overrun   <= (fft_done && (state_reg != ST_IDLE))
                      || ((state_reg == ST_CAPTURE) && result_valid && !result_ready);
            if (result_valid && result_ready) begin
                result_valid <= 1'b0;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (fft_done) begin
                        state_reg <= ST_CLEAR;
                        det_clear <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state_reg <= ST_SCAN;
                    rd_en     <= 1'b1;
                    rd_addr   <= '0;
                end
                ST_SCAN: begin
                    if (rd_addr == LAST_ADDR) begin
                        state_reg     <= ST_DRAIN;
                        rd_en         <= 1'b0;
                        rd_addr       <= '0;
                        drain_cnt_reg <= '0;
                    end else begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // RD_LAT cycles of flush plus one for the detector's registered update.
                    if (drain_cnt_reg == DRAIN_LAST) begin
                        state_reg <= ST_CAPTURE;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + 3'd1;
                    end
                end
                ST_CAPTURE: begin
                    state_reg    <= ST_IDLE;
                    busy         <= 1'b0;
                    result_idx   <= peak_idx_in;
                    result_valid <= 1'b1;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                    rd_en     <= 1'b0;
                end
            endcase
        end
    end

    scan_align_pipe #(
        .RD_LAT (RD_LAT),
        .IDX_W  (ADDR_W)
    ) u_align (
        .clk       (clk),
        .reset_fft (reset_fft),
        .in_en     (pipe_en),
        .in_idx    (rd_addr),
        .out_en    (det_en),
        .out_idx   (det_index)
    );

endmodule

// File: tb/tb_fft_peak_scan_ctrl.sv
// Three controllers (default, RD_LAT=3, SKIP_DC=0) share stimulus; each drives a
// detector/RAM model, and results are compared with an argmax over the frame.
module tb_fft_peak_scan_ctrl;

    logic clk = 1'b0;
    logic reset_fft, fft_done, result_ready;

    logic       rd_en_a, det_clear_a, det_en_a, result_valid_a, busy_a, overrun_a;
    logic [8:0] rd_addr_a, det_index_a;
    logic [9:0] peak_a = '0, result_idx_a;
    logic       rd_en_b, det_clear_b, det_en_b, result_valid_b, busy_b, overrun_b;
    logic [8:0] rd_addr_b, det_index_b;
    logic [9:0] peak_b = '0, result_idx_b;
    logic       rd_en_c, det_clear_c, det_en_c, result_valid_c, busy_c, overrun_c;
    logic [8:0] rd_addr_c, det_index_c;
    logic [9:0] peak_c = '0, result_idx_c;

    int n_tests = 0;
    int n_fail  = 0;

    int mag [3][512];
    logic [9:0] ref_a, ref_b, ref_c;

    int clr_a, scan_a, contig_a, first_en_a, ov_a, caps_a, lat_a;
    logic vlat_a;
    int scan_c, first_en_c, ov_c, lat_c, ov_b, lat_b, align_b;

    always #5 clk = ~clk;

    fft_peak_scan_ctrl #(.SCAN_LEN(256), .ADDR_W(9), .RD_LAT(2), .SKIP_DC(1)) dut_a (
        .clk(clk), .reset_fft(reset_fft), .fft_done(fft_done),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .det_clear(det_clear_a),
        .det_en(det_en_a), .det_index(det_index_a), .peak_idx_in(peak_a),
        .result_idx(result_idx_a), .result_valid(result_valid_a),
        .result_ready(result_ready), .busy(busy_a), .overrun(overrun_a));

    fft_peak_scan_ctrl #(.SCAN_LEN(256), .ADDR_W(9), .RD_LAT(3), .SKIP_DC(1)) dut_b (
        .clk(clk), .reset_fft(reset_fft), .fft_done(fft_done),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .det_clear(det_clear_b),
        .det_en(det_en_b), .det_index(det_index_b), .peak_idx_in(peak_b),
        .result_idx(result_idx_b), .result_valid(result_valid_b),
        .result_ready(result_ready), .busy(busy_b), .overrun(overrun_b));

    fft_peak_scan_ctrl #(.SCAN_LEN(256), .ADDR_W(9), .RD_LAT(2), .SKIP_DC(0)) dut_c (
        .clk(clk), .reset_fft(reset_fft), .fft_done(fft_done),
        .rd_en(rd_en_c), .rd_addr(rd_addr_c), .det_clear(det_clear_c),
        .det_en(det_en_c), .det_index(det_index_c), .peak_idx_in(peak_c),
        .result_idx(result_idx_c), .result_valid(result_valid_c),
        .result_ready(result_ready), .busy(busy_c), .overrun(overrun_c));

    // Pair-wise detector: data comes from the RAM address issued RD_LAT cycles ago,
    // the reported bin index comes from det_index.
    function automatic void det_next(input int d, input logic [8:0] ra, input logic [8:0] di,
                                     input int cur_mx, input logic [9:0] cur_pk,
                                     output int nmx, output logic [9:0] npk);
        nmx = cur_mx;
        npk = cur_pk;
        if (mag[d][{ra, 1'b0}] > nmx) begin nmx = mag[d][{ra, 1'b0}]; npk = {di, 1'b0}; end
        if (mag[d][{ra, 1'b1}] > nmx) begin nmx = mag[d][{ra, 1'b1}]; npk = {di, 1'b1}; end
    endfunction

    logic [8:0] dly_a [2] = '{default: '0};
    logic [8:0] dly_b [3] = '{default: '0};
    logic [8:0] dly_c [2] = '{default: '0};
    int mx_a = 0, mx_b = 0, mx_c = 0, nmx_a, nmx_b, nmx_c;
    logic [9:0] npk_a, npk_b, npk_c;

    always @(posedge clk) begin
        dly_a[0] <= rd_addr_a;
        dly_a[1] <= dly_a[0];
        if (det_clear_a) begin mx_a <= 0; peak_a <= '0; end
        else if (det_en_a) begin
            det_next(0, dly_a[1], det_index_a, mx_a, peak_a, nmx_a, npk_a);
            mx_a <= nmx_a; peak_a <= npk_a;
        end
    end

    always @(posedge clk) begin
        dly_b[0] <= rd_addr_b;
        dly_b[1] <= dly_b[0];
        dly_b[2] <= dly_b[1];
        if (det_clear_b) begin mx_b <= 0; peak_b <= '0; end
        else if (det_en_b) begin
            det_next(1, dly_b[2], det_index_b, mx_b, peak_b, nmx_b, npk_b);
            mx_b <= nmx_b; peak_b <= npk_b;
        end
    end

    always @(posedge clk) begin
        dly_c[0] <= rd_addr_c;
        dly_c[1] <= dly_c[0];
        if (det_clear_c) begin mx_c <= 0; peak_c <= '0; end
        else if (det_en_c) begin
            det_next(2, dly_c[1], det_index_c, mx_c, peak_c, nmx_c, npk_c);
            mx_c <= nmx_c; peak_c <= npk_c;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Expected peak: first strictly-largest magnitude among the bins the detector may see.
    function automatic logic [9:0] ref_peak(input int d, input bit skip_dc);
        int best = 0;
        logic [9:0] bi = '0;
        for (int b = (skip_dc ? 2 : 0); b < 512; b++) begin
            if (mag[d][b] > best) begin best = mag[d][b]; bi = 10'(b); end
        end
        return bi;
    endfunction

    task automatic gen_frame(input int pk_bin_a);
        for (int d = 0; d < 3; d++)
            for (int b = 0; b < 512; b++)
                mag[d][b] = int'($urandom_range(1, 1000));
        mag[0][pk_bin_a] = 5000;
        mag[1][$urandom_range(2, 511)] = 5000;
        mag[2][$urandom_range(0, 1)] = 5000;
        ref_a = ref_peak(0, 1'b1);
        ref_b = ref_peak(1, 1'b1);
        ref_c = ref_peak(2, 1'b0);
    endtask

    task automatic run_frame(input bit rdy, input int rdy_on_n, input int drop_addr);
        logic [8:0] h_addr [3];
        logic       h_en [3];
        bit drop_done = 1'b0;
        bit pb_a, pb_b, pb_c;
        int exp_a = 0;
        clr_a = 0; scan_a = 0; contig_a = 0; first_en_a = -1; ov_a = 0; caps_a = 0;
        lat_a = -1; vlat_a = 1'b0;
        scan_c = 0; first_en_c = -1; ov_c = 0; lat_c = -1;
        ov_b = 0; lat_b = -1; align_b = 0;
        for (int i = 0; i < 3; i++) begin h_addr[i] = rd_addr_b; h_en[i] = rd_en_b; end
        pb_a = busy_a; pb_b = busy_b; pb_c = busy_c;
        result_ready = rdy;
        fft_done = 1'b1;
        for (int n = 1; n <= 275; n++) begin
            @(negedge clk);
            fft_done = 1'b0;
            if (det_clear_a) clr_a++;
            if (rd_en_a) begin
                if (rd_addr_a != 9'(exp_a)) contig_a++;
                exp_a++;
                scan_a++;
            end
            if (det_en_a && first_en_a < 0) first_en_a = int'(det_index_a);
            if (overrun_a) ov_a++;
            if (pb_a && !busy_a) begin
                caps_a++;
                if (lat_a < 0) begin lat_a = n; vlat_a = result_valid_a; end
            end
            if (rd_en_c) scan_c++;
            if (det_en_c && first_en_c < 0) first_en_c = int'(det_index_c);
            if (overrun_c) ov_c++;
            if (pb_c && !busy_c && lat_c < 0) lat_c = n;
            if (overrun_b) ov_b++;
            if (pb_b && !busy_b && lat_b < 0) lat_b = n;
            if (det_index_b !== h_addr[2] || det_en_b !== (h_en[2] && h_addr[2] != 9'd0))
                align_b++;
            h_addr[2] = h_addr[1]; h_addr[1] = h_addr[0]; h_addr[0] = rd_addr_b;
            h_en[2]   = h_en[1];   h_en[1]   = h_en[0];   h_en[0]   = rd_en_b;
            pb_a = busy_a; pb_b = busy_b; pb_c = busy_c;
            if (n == rdy_on_n) result_ready = 1'b1;
            if (!drop_done && drop_addr >= 0 && rd_en_a && int'(rd_addr_a) == drop_addr) begin
                fft_done  = 1'b1;
                drop_done = 1'b1;
            end
        end
    endtask

    initial begin
        bit found;
        reset_fft = 1'b1; fft_done = 1'b0; result_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_fft = 1'b0;
        @(negedge clk);
        chk("rst_rd_en", rd_en_a, 0);
        chk("rst_rd_addr", rd_addr_a, 0);
        chk("rst_det_clear", det_clear_a, 0);
        chk("rst_det_en", det_en_a, 0);
        chk("rst_det_index", det_index_a, 0);
        chk("rst_result_idx", result_idx_a, 0);
        chk("rst_result_valid", result_valid_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_overrun", overrun_a, 0);

        // Basic frame: peak at pair 37, upper bin
        gen_frame(75);
        run_frame(1'b0, -1, -1);
        $display("[TB] frame1 basic: lat=%0d idx=%0d ov=%0d", lat_a, result_idx_a, ov_a);
        chk("f1_clear_cycles", clr_a, 1);
        chk("f1_scan_len", scan_a, 256);
        chk("f1_addr_contig_err", contig_a, 0);
        chk("f1_first_det_en_idx", first_en_a, 1);
        chk("f1_latency", lat_a, 262);
        chk("f1_valid_at_latency", vlat_a, 1);
        chk("f1_result_idx", result_idx_a, 75);
        chk("f1_overrun", ov_a, 0);
        chk("f1_b_align_err", align_b, 0);
        chk("f1_b_latency", lat_b, 263);
        chk("f1_b_result_idx", result_idx_b, ref_b);
        chk("f1_c_first_det_en_idx", first_en_c, 0);
        chk("f1_c_scan_len", scan_c, 256);
        chk("f1_c_result_idx", result_idx_c, ref_c);
        chk("f1_c_latency", lat_c, 262);

        // Second frame with the first result unconsumed
        gen_frame(int'($urandom_range(2, 511)));
        run_frame(1'b0, -1, -1);
        $display("[TB] frame2 overwrite: idx=%0d ov=%0d", result_idx_a, ov_a);
        chk("f2_overrun", ov_a, 1);
        chk("f2_result_idx", result_idx_a, ref_a);
        chk("f2_result_valid", result_valid_a, 1);
        chk("f2_b_overrun", ov_b, 1);
        chk("f2_b_align_err", align_b, 0);
        chk("f2_c_result_idx", result_idx_c, ref_c);
        chk("f2_c_result_valid", result_valid_c, 1);

        // Consumer accepts on the capture cycle
        gen_frame(int'($urandom_range(2, 511)));
        run_frame(1'b0, 261, -1);
        $display("[TB] frame3 accept-on-capture: idx=%0d ov=%0d", result_idx_a, ov_a);
        chk("f3_overrun", ov_a, 0);
        chk("f3_valid_at_latency", vlat_a, 1);
        chk("f3_result_idx", result_idx_a, ref_a);
        chk("f3_valid_after_accept", result_valid_a, 0);
        chk("f3_b_overrun", ov_b, 0);
        chk("f3_c_overrun", ov_c, 0);

        // fft_done arriving mid-scan is dropped
        gen_frame(int'($urandom_range(2, 511)));
        run_frame(1'b1, -1, 100);
        $display("[TB] frame4 busy drop: caps=%0d scan=%0d ov=%0d", caps_a, scan_a, ov_a);
        chk("f4_overrun", ov_a, 1);
        chk("f4_captures", caps_a, 1);
        chk("f4_scan_len", scan_a, 256);
        chk("f4_addr_contig_err", contig_a, 0);
        chk("f4_result_idx", result_idx_a, ref_a);
        chk("f4_busy_end", busy_a, 0);

        // Asynchronous reset in the middle of a scan
        found = 1'b0;
        fft_done = 1'b1;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            fft_done = 1'b0;
            if (rd_en_a && rd_addr_a == 9'd50) found = 1'b1;
        end
        chk("f5_reached_addr50", found, 1);
        reset_fft = 1'b1;
        #1;
        $display("[TB] frame5 reset at addr 50: rd_en=%0d busy=%0d", rd_en_a, busy_a);
        chk("f5_rst_rd_en", rd_en_a, 0);
        chk("f5_rst_rd_addr", rd_addr_a, 0);
        chk("f5_rst_busy", busy_a, 0);
        chk("f5_rst_det_en", det_en_a, 0);
        chk("f5_rst_det_index", det_index_a, 0);
        chk("f5_rst_result_valid", result_valid_a, 0);
        chk("f5_rst_result_idx", result_idx_a, 0);
        repeat (2) @(negedge clk);
        reset_fft = 1'b0;
        repeat (3) @(negedge clk);
        chk("f5_idle_busy", busy_a, 0);
        chk("f5_idle_rd_en", rd_en_a, 0);
        gen_frame(int'($urandom_range(2, 511)));
        run_frame(1'b1, -1, -1);
        $display("[TB] frame6 after reset: lat=%0d idx=%0d", lat_a, result_idx_a);
        chk("f6_clear_cycles", clr_a, 1);
        chk("f6_scan_len", scan_a, 256);
        chk("f6_addr_contig_err", contig_a, 0);
        chk("f6_latency", lat_a, 262);
        chk("f6_result_idx", result_idx_a, ref_a);
        chk("f6_overrun", ov_a, 0);
        chk("f6_b_align_err", align_b, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
